// File: rtl/circle_point_pipe.sv
// rtl/circle_point_pipe.sv - 3-stage valid/ready pipeline mapping a 16.16 VdCorput fraction to (cos, sin, angle) on the unit circle
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_vdc is a 16.16 unsigned value (integer bits ignored)
//   out_valid/out_ready   output handshake
//   out_cos, out_sin      signed 16.16 cos/sin of 2*pi*frac
//   out_angle             angle in radians, unsigned 16.16
//   out_index             sequence number of the sample currently presented
module circle_point_pipe #(
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_vdc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_cos,
   output logic [31:0]      out_sin,
   output logic [31:0]      out_angle,
   output logic [CNT_W-1:0] out_index
);

   localparam int N = 1 << LUT_AW;

   // Quarter-wave table entry round(sin(i*pi/(2N)) * 65536), evaluated at
   // elaboration with a Taylor series in 2^-40 fixed point so the table
   // follows LUT_AW without a hand-maintained constant list.
   function automatic logic [31:0] lut_val(input int i);
      logic [127:0] x, x2, term, sp, sn, r;
      if (i == 0) return 32'h0000_0000;
      if (i == N) return 32'h0001_0000;
      // pi * 2^40
      x    = (128'(i) * 128'd3454217652358) >> (LUT_AW + 1);
      x2   = (x * x) >> 40;
      term = x;
      sp   = x;
      sn   = '0;
      for (int k = 1; k <= 12; k++) begin
         term = ((term * x2) >> 40) / 128'((2 * k) * (2 * k + 1));
         if (k % 2 == 1) sn = sn + term;
         else            sp = sp + term;
      end
      r = (sp - sn + (128'd1 << 23)) >> 24;
      return r[31:0];
   endfunction

   logic [31:0] lut [0:N];

   for (genvar g = 0; g <= N; g++) begin : g_lut
      localparam logic [31:0] VAL = lut_val(g);
      assign lut[g] = VAL;
   end

   // All three stages move in lockstep; the only stall point is the output.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic [PHASE_W-1:0] phase;
   logic [47:0]        angle_prod;
   assign phase      = in_vdc[15 -: PHASE_W];
   assign angle_prod = {16'h0000, in_vdc[15:0]} * {16'h0000, 32'h0006_487F};

   logic unused_bits;
   assign unused_bits = ^{in_vdc[31:16], phase, angle_prod[15:0]};

   // Stage 1: phase split
   logic              s1_valid;
   logic [1:0]        s1_q;
   logic [LUT_AW-1:0] s1_idx;
   logic [31:0]       s1_angle;

   // Stage 2: table reads, ta = T[idx], tb = T[N-idx]
   logic              s2_valid;
   logic [1:0]        s2_q;
   logic [31:0]       s2_ta;
   logic [31:0]       s2_tb;
   logic [31:0]       s2_angle;

   logic [LUT_AW:0] addr_a;
   logic [LUT_AW:0] addr_b;
   assign addr_a = {1'b0, s1_idx};
   assign addr_b = (LUT_AW + 1)'(N) - addr_a;

   // Stage 3 quadrant fold; negating a zero entry stays zero in 2's complement.
   logic [31:0] cos_n;
   logic [31:0] sin_n;
   always_comb begin
      sin_n = s2_ta;
      cos_n = s2_tb;
      case (s2_q)
         2'd1: begin sin_n =  s2_tb; cos_n = -s2_ta; end
         2'd2: begin sin_n = -s2_ta; cos_n = -s2_tb; end
         2'd3: begin sin_n = -s2_tb; cos_n =  s2_ta; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_q      <= '0;
         s1_idx    <= '0;
         s1_angle  <= '0;
         s2_valid  <= 1'b0;
         s2_q      <= '0;
         s2_ta     <= '0;
         s2_tb     <= '0;
         s2_angle  <= '0;
         out_valid <= 1'b0;
         out_cos   <= '0;
         out_sin   <= '0;
         out_angle <= '0;
         out_index <= '0;
      end else begin
         if (en) begin
            s1_valid  <= in_valid;
            s1_q      <= phase[PHASE_W-1 -: 2];
            s1_idx    <= phase[PHASE_W-3 -: LUT_AW];
            s1_angle  <= angle_prod[47:16];
            s2_valid  <= s1_valid;
            s2_q      <= s1_q;
            s2_ta     <= lut[addr_a];
            s2_tb     <= lut[addr_b];
            s2_angle  <= s1_angle;
            out_valid <= s2_valid;
            out_cos   <= cos_n;
            out_sin   <= sin_n;
            out_angle <= s2_angle;
         end
         if (out_valid && out_ready) out_index <= out_index + 1'b1;
      end
   end

endmodule

// File: tb/tb_circle_point_pipe.sv
// tb/tb_circle_point_pipe.sv - self-checking bench for circle_point_pipe
module tb_circle_point_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_vdc;
   logic        in_ready, out_valid;
   logic [31:0] out_cos, out_sin, out_angle;
   logic [15:0] out_index;
   logic        in_ready2, out_valid2;
   logic [31:0] out_cos2, out_sin2, out_angle2;
   logic [1:0]  out_index2;

   circle_point_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vdc(in_vdc),
      .out_valid(out_valid), .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
      .out_angle(out_angle), .out_index(out_index)
   );

   circle_point_pipe #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_vdc(in_vdc),
      .out_valid(out_valid2), .out_ready(out_ready), .out_cos(out_cos2), .out_sin(out_sin2),
      .out_angle(out_angle2), .out_index(out_index2)
   );

   typedef struct {
      logic [31:0] vdc;
      logic [31:0] cos_e;
      logic [31:0] sin_e;
      logic [31:0] angle_e;
   } vec_t;

   typedef struct {
      logic [31:0] c;
      logic [31:0] s;
      logic [31:0] a;
      logic [15:0] idx;
      logic [1:0]  idx2;
      int          cyc;
   } pop_t;

   vec_t vecs [6];
   pop_t got [$];
   int   stim [$];
   int   sent, cyc, n_checks, n_fail, hold_bad, stall_ready_bad, exp_idx, base;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, settle, then record the handshakes that the
   // next rising edge will perform.
   task automatic run(input int ncyc, input int stall_from, input int stall_len);
      logic        hold;
      logic [31:0] hc, hs, ha;
      logic [15:0] hi;
      pop_t        p;
      hold = 1'b0; hc = '0; hs = '0; ha = '0; hi = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (hold) begin
            if (out_valid !== 1'b1 || out_cos !== hc || out_sin !== hs ||
                out_angle !== ha || out_index !== hi) hold_bad++;
         end
         if (sent < stim.size()) begin
            in_valid = 1'b1;
            in_vdc   = vecs[stim[sent]].vdc;
         end else begin
            in_valid = 1'b0;
            in_vdc   = 32'h0;
         end
         out_ready = !(c >= stall_from && c < stall_from + stall_len);
         #1;
         if (out_valid && !out_ready && in_ready) stall_ready_bad++;
         hold = out_valid && !out_ready;
         hc = out_cos; hs = out_sin; ha = out_angle; hi = out_index;
         if (out_valid && out_ready) begin
            p.c = out_cos; p.s = out_sin; p.a = out_angle;
            p.idx = out_index; p.idx2 = out_index2; p.cyc = cyc;
            got.push_back(p);
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
   endtask

   task automatic start(input int n, input int first);
      stim.delete();
      got.delete();
      sent = 0;
      for (int k = 0; k < n; k++) stim.push_back((first + k) % 6);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{32'h0000_4000, 32'h0000_0000, 32'h0001_0000, 32'h0001_921F};
      vecs[2] = '{32'h0000_8000, 32'hFFFF_0000, 32'h0000_0000, 32'h0003_243F};
      vecs[3] = '{32'h0000_C000, 32'h0000_0000, 32'hFFFF_0000, 32'h0004_B65F};
      vecs[4] = '{32'h0000_2000, 32'h0000_B505, 32'h0000_B505, 32'h0000_C90F};
      vecs[5] = '{32'h0001_8000, 32'hFFFF_0000, 32'h0000_0000, 32'h0003_243F};

      n_checks = 0; n_fail = 0; hold_bad = 0; stall_ready_bad = 0;
      sent = 0; cyc = 0; exp_idx = 0;
      rst_n = 1'b0; in_valid = 1'b0; in_vdc = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_cos",   out_cos,   32'd0);
      check("reset_out_sin",   out_sin,   32'd0);
      check("reset_out_angle", out_angle, 32'd0);
      check("reset_out_index", 32'(out_index), 32'd0);
      check("reset_in_ready",  32'(in_ready),  32'd1);

      // Single samples through an empty pipe
      for (int i = 0; i < 6; i++) begin
         start(1, i);
         base = cyc;
         run(8, 99, 0);
         check($sformatf("vec%0d_count", i), 32'(got.size()), 32'd1);
         if (got.size() >= 1) begin
            check($sformatf("vec%0d_cos", i),     got[0].c, vecs[i].cos_e);
            check($sformatf("vec%0d_sin", i),     got[0].s, vecs[i].sin_e);
            check($sformatf("vec%0d_angle", i),   got[0].a, vecs[i].angle_e);
            check($sformatf("vec%0d_index", i),   32'(got[0].idx), 32'(exp_idx));
            check($sformatf("vec%0d_latency", i), 32'(got[0].cyc - base), 32'd3);
            exp_idx++;
         end
      end

      // Back-to-back quadrant points at full throughput
      start(4, 0);
      run(10, 99, 0);
      check("b2b_count", 32'(got.size()), 32'd4);
      for (int k = 0; k < 4 && k < got.size(); k++) begin
         check($sformatf("b2b_cos%0d", k),   got[k].c, vecs[k].cos_e);
         check($sformatf("b2b_index%0d", k), 32'(got[k].idx), 32'(exp_idx));
         check($sformatf("b2b_cyc%0d", k),   32'(got[k].cyc - got[0].cyc), 32'(k));
         exp_idx++;
      end

      // Output stall for 5 cycles mid-stream
      start(8, 1);
      run(24, 5, 5);
      check("stall_count", 32'(got.size()), 32'd8);
      for (int k = 0; k < 8 && k < got.size(); k++) begin
         check($sformatf("stall_cos%0d", k),   got[k].c, vecs[(1 + k) % 6].cos_e);
         check($sformatf("stall_sin%0d", k),   got[k].s, vecs[(1 + k) % 6].sin_e);
         check($sformatf("stall_index%0d", k), 32'(got[k].idx), 32'(exp_idx));
         exp_idx++;
      end
      check("stall_hold_stable", 32'(hold_bad), 32'd0);
      check("stall_in_ready_low", 32'(stall_ready_bad), 32'd0);

      // Reset with two samples in flight
      start(2, 1);
      run(2, 99, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      start(1, 2);
      run(10, 99, 0);
      check("rst_after_count", 32'(got.size()), 32'd1);
      if (got.size() >= 1) begin
         check("rst_after_cos",   got[0].c, vecs[2].cos_e);
         check("rst_after_index", 32'(got[0].idx), 32'd0);
      end

      // Narrow counter wrap
      do_reset();
      start(5, 0);
      run(12, 99, 0);
      check("cnt2_count", 32'(got.size()), 32'd5);
      for (int k = 0; k < 5 && k < got.size(); k++)
         check($sformatf("cnt2_index%0d", k), 32'(got[k].idx2), 32'(k % 4));
      exp_idx = 5;

      // Full phase sweep against real cos/sin
      begin
         int          np, nr, cos_bad, sin_bad, ang_bad, idx_bad;
         real         ang, ec, es, max_e;
         logic [47:0] prod;
         np = 0; nr = 0; cos_bad = 0; sin_bad = 0; ang_bad = 0; idx_bad = 0; max_e = 0.0;
         for (int c = 0; c < 65536 + 40 && nr < 65536; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (np < 65536);
            in_vdc    = {16'h0000, 16'(np)};
            #1;
            if (out_valid) begin
               ang = 2.0 * 3.14159265358979 * real'(nr) / 65536.0;
               ec = real'($signed(out_cos)) / 65536.0 - $cos(ang);
               es = real'($signed(out_sin)) / 65536.0 - $sin(ang);
               if (ec < 0.0) ec = -ec;
               if (es < 0.0) es = -es;
               if (ec > max_e) max_e = ec;
               if (es > max_e) max_e = es;
               if (ec > 1.0 / 64.0) cos_bad++;
               if (es > 1.0 / 64.0) sin_bad++;
               prod = 48'(nr) * 48'h0006_487F;
               if (out_angle !== prod[47:16]) ang_bad++;
               if (out_index !== 16'(exp_idx + nr)) idx_bad++;
               nr++;
            end
            if (in_valid && in_ready) np++;
         end
         in_valid = 1'b0;
         check("sweep_count", 32'(nr), 32'd65536);
         check("sweep_cos_err", 32'(cos_bad), 32'd0);
         check("sweep_sin_err", 32'(sin_bad), 32'd0);
         check("sweep_angle", 32'(ang_bad), 32'd0);
         check("sweep_index", 32'(idx_bad), 32'd0);
         $display("sweep max abs error %f", max_e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
